hazard_unit: RTL and testbench
==============================

# hazard_unit

Tracks in-flight destination registers for the 4-stage pipeline (IF, ID, EX, WB) and drives the forwarding-mux select codes `rs1_hazard`/`rs2_hazard` consumed in EX. It also freezes the pipeline while a load in WB waits on data memory, and counts stall cycles.

- Upstream: sits between ID decode and the EX forwarding mux.
- Selects are computed from ID-stage operands and registered, so they belong to the instruction occupying EX.

## Interface
Parameters
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the instruction actually reads that source.
- `id_rd`  in  5  destination index in ID.
- `id_regwrite`  in  1  ID instruction writes `rd`.
- `id_memtoreg`  in  1  ID instruction is a load.
- `flush`  in  1  branch/jump resolved taken in EX; kill the ID instruction.
- `dmem_ready`  in  1  load data on `memtoreg_data` is valid this cycle.
- `rs1_hazard`, `rs2_hazard`  out  2 each  forwarding selects for EX: 00 = register file, 01 = `result`, 10 = `memtoreg_data`. 11 is never driven.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/WB registers.
- `ex_valid`, `wb_valid`  out  1 each  slot occupancy.
- `wb_rd`  out  5  destination of the WB slot.
- `wb_regwrite`  out  1  WB slot writes the register file (already gated by `wb_valid`).
- `stall_cnt`  out  `CNT_W`  stall cycles since reset, saturating.

## Operation
- Internal slots:
  - EX slot: `valid`, `rd`, `regwrite`, `memtoreg`.
  - WB slot: same fields.
- `stall` is combinational: `wb_valid & wb_memtoreg & ~dmem_ready`.
- FSM, two states:
  - RUN → WAIT_MEM when `stall` is 1 at a clock edge.
  - WAIT_MEM → RUN on the first edge where `stall` is 0.
  - WAIT_MEM is used only for counting and for asserting in the bench.
- Advance (edge with `rst_n=1`, `stall=0`):
  - WB slot ← EX slot.
  - EX slot ← ID fields when `id_valid & ~flush`; otherwise EX slot ← bubble (`valid=0`, `regwrite=0`).
  - `rsX_hazard` ← selX, computed from the ID operands against the current EX slot (the producer that will sit in WB when the consumer reaches EX).
  - A bubble or flushed entry loads selects 00.
- selX:
  - Match = EX valid, EX regwrite, EX `rd` ≠ 0, `id_usesX`, and `id_rsX` = EX `rd`.
  - Match with EX `memtoreg` = 0 → 01.
  - Match with EX `memtoreg` = 1 → 10.
  - No match → 00.
- Distance-2 producers need no forwarding: the register file is write-first.
- Hold (`stall=1`):
  - Slots, selects and state hold.
  - `flush` is ignored; EX is frozen and cannot resolve a branch.
  - `stall_cnt` increments by 1 and saturates at all-ones.
- x0 never forwards, even when `regwrite=1`.
- `rs1` and `rs2` select independently; both may be nonzero in the same cycle.

## Timing
- Reset (edge with `rst_n=0`; takes priority over `stall`):
  - All slots invalid.
  - `rs1_hazard=rs2_hazard=00`, `wb_rd=0`, `wb_regwrite=0`, `ex_valid=wb_valid=0`.
  - `stall_cnt=0`, state RUN.
  - `stall` reads 0 after reset because `wb_valid=0`.
- Latency:
  - Selects appear one cycle after the consumer is in ID, aligned with the consumer in EX.
  - `stall` has zero latency relative to `dmem_ready`.
- Load-data stall:
  - The load holds WB until the cycle `dmem_ready=1`.
  - On that edge the pipe advances; a dependent in EX sees `memtoreg_data` with select 10 during the ready cycle.
- `dmem_ready` already high when the load enters WB → no stall cycle.
- Simultaneous `flush` and `id_valid` with `stall=0` → bubble wins.
- Reset mid-stall → RUN, counter cleared, slots empty on the next cycle.

## Test plan
- Back-to-back ALU dependency:
  - Stimulus: `add x5,...` then `sub x6,x5,x5` in successive ID cycles.
  - Response: with `sub` in EX, `rs1_hazard=rs2_hazard=01`, `stall=0`.
- Load-use with 3-cycle memory:
  - Stimulus: `lw x7`, then `add x8,x7,x0`; `dmem_ready` low for 3 cycles after the load enters WB.
  - Response: `stall=1` for exactly 3 cycles, `stall_cnt=3`, `rs1_hazard=10` held throughout, `rs2_hazard=00`.
- x0 and unused-operand suppression:
  - Stimulus: producer with `rd=0`, `regwrite=1`; then a consumer of `x0`; then a consumer with `id_uses_rs2=0` whose `rs2` matches.
  - Response: both selects 00 in each case.
- Flush:
  - Stimulus: `flush=1` with a matching ID instruction.
  - Response: next cycle `ex_valid=0`, selects 00. The following instruction depending on the flushed `rd` gets 00.
- Reset mid-stall:
  - Stimulus: assert `rst_n=0` during the 2nd stall cycle.
  - Response: next cycle `stall=0`, `stall_cnt=0`, all valids 0, selects 00.
- Counter saturation:
  - Stimulus: `CNT_W=4`, hold `dmem_ready=0` for 20 cycles.
  - Response: `stall_cnt` stops at 15; selects never 11.

Source files
------------

// File: rtl/hazard_unit.sv
//==============================================================================
// Module   : hazard_unit
// Brief    : Forwarding-select generation, load-data stall and stall counter
//            for the 4-stage IF/ID/EX/WB pipeline.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             flush,
    input  logic             dmem_ready,
    output logic [1:0]       rs1_hazard,
    output logic [1:0]       rs2_hazard,
    output logic             stall,
    output logic             ex_valid,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic             wb_regwrite,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF     = 2'b00;
    localparam logic [1:0] SEL_RESULT = 2'b01;
    localparam logic [1:0] SEL_MEM    = 2'b10;

    state_t           state_q, state_d;
    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_regwrite_q, ex_regwrite_d;
    logic             ex_memtoreg_q, ex_memtoreg_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic             wb_memtoreg_q, wb_memtoreg_d;
    logic [1:0]       rs1_sel_q, rs1_sel_d;
    logic [1:0]       rs2_sel_q, rs2_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_id_take;

    // The EX occupant is the producer that sits in WB once the ID consumer reaches EX.
    function automatic logic [1:0] fwd_sel(
        input logic       uses,
        input logic [4:0] rs,
        input logic       p_valid,
        input logic       p_regwrite,
        input logic       p_memtoreg,
        input logic [4:0] p_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (p_valid && p_regwrite && (p_rd != 5'd0) && uses && (rs == p_rd))
            sel = p_memtoreg ? SEL_MEM : SEL_RESULT;
        return sel;
    endfunction

    assign stall     = wb_valid_q & wb_memtoreg_q & ~dmem_ready;
    assign w_id_take = id_valid & ~flush;

    always_comb begin
        state_d       = state_q;
        ex_valid_d    = ex_valid_q;
        ex_rd_d       = ex_rd_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memtoreg_d = ex_memtoreg_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        rs1_sel_d     = rs1_sel_q;
        rs2_sel_d     = rs2_sel_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_RUN:      if (stall)  state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: if (!stall) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        if (stall) begin
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end else begin
            wb_valid_d    = ex_valid_q;
            wb_rd_d       = ex_rd_q;
            wb_regwrite_d = ex_regwrite_q;
            wb_memtoreg_d = ex_memtoreg_q;

            ex_valid_d    = w_id_take;
            ex_rd_d       = w_id_take ? id_rd : 5'd0;
            ex_regwrite_d = w_id_take & id_regwrite;
            ex_memtoreg_d = w_id_take & id_memtoreg;

            rs1_sel_d = SEL_RF;
            rs2_sel_d = SEL_RF;
            if (w_id_take) begin
                rs1_sel_d = fwd_sel(id_uses_rs1, id_rs1, ex_valid_q, ex_regwrite_q,
                                    ex_memtoreg_q, ex_rd_q);
                rs2_sel_d = fwd_sel(id_uses_rs2, id_rs2, ex_valid_q, ex_regwrite_q,
                                    ex_memtoreg_q, ex_rd_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= 5'd0;
            ex_regwrite_q <= 1'b0;
            ex_memtoreg_q <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            rs1_sel_q     <= SEL_RF;
            rs2_sel_q     <= SEL_RF;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memtoreg_q <= ex_memtoreg_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            rs1_sel_q     <= rs1_sel_d;
            rs2_sel_q     <= rs2_sel_d;
            cnt_q         <= cnt_d;
        end
    end

    assign rs1_hazard  = rs1_sel_q;
    assign rs2_hazard  = rs2_sel_q;
    assign ex_valid    = ex_valid_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_regwrite = wb_valid_q & wb_regwrite_q;
    assign stall_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//==============================================================================
// Module   : tb_hazard_unit
// Brief    : Directed, self-checking bench for hazard_unit (4-bit stall counter).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             id_regwrite, id_memtoreg;
    logic             flush;
    logic             dmem_ready;
    logic [1:0]       rs1_hazard, rs2_hazard;
    logic             stall, ex_valid, wb_valid, wb_regwrite;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memtoreg (id_memtoreg),
        .flush       (flush),
        .dmem_ready  (dmem_ready),
        .rs1_hazard  (rs1_hazard),
        .rs2_hazard  (rs2_hazard),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic [4:0] rd,
                            input logic rw, input logic mtr);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memtoreg = mtr;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; dmem_ready = 1'b1;
        idle_id();
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (rs1_hazard !== 2'b00) begin n_fail++; $display("FAIL reset_rs1 got %b exp 00", rs1_hazard); end
        n_tests++; if (rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL reset_rs2 got %b exp 00", rs2_hazard); end
        n_tests++; if (ex_valid !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got ex=%b wb=%b exp 0 0", ex_valid, wb_valid); end
        n_tests++; if (wb_rd !== 5'd0 || wb_regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_wb got rd=%0d rw=%b exp 0 0", wb_rd, wb_regwrite); end
        n_tests++; if (stall_cnt !== 4'd0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got cnt=%0d stall=%b exp 0 0", stall_cnt, stall); end
    endtask

    task automatic test_back_to_back();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
        tick();
        n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_ex_valid got %b exp 1", ex_valid); end
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x5
        tick();
        n_tests++; if (rs1_hazard !== 2'b01 || rs2_hazard !== 2'b01) begin n_fail++; $display("FAIL b2b_sel got %b/%b exp 01/01", rs1_hazard, rs2_hazard); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b exp 0", stall); end
        n_tests++; if (wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin n_fail++; $display("FAIL b2b_wb got rd=%0d rw=%b exp 5 1", wb_rd, wb_regwrite); end
        idle_id();
        tick();
        n_tests++; if (rs1_hazard !== 2'b00 || wb_rd !== 5'd6) begin n_fail++; $display("FAIL b2b_drain got sel=%b rd=%0d exp 00 6", rs1_hazard, wb_rd); end
        tick();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        drive_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
        dmem_ready = 1'b0;
        tick();
        idle_id();
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall[%0d] got %b exp 1", i, stall); end
            n_tests++; if (rs1_hazard !== 2'b10 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL lu_sel[%0d] got %b/%b exp 10/00", i, rs1_hazard, rs2_hazard); end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL lu_ready got stall=%b cnt=%0d exp 0 3", stall, stall_cnt); end
        n_tests++; if (rs1_hazard !== 2'b10 || wb_rd !== 5'd7) begin n_fail++; $display("FAIL lu_ready_sel got sel=%b rd=%0d exp 10 7", rs1_hazard, wb_rd); end
        tick();
        n_tests++; if (wb_rd !== 5'd8 || rs1_hazard !== 2'b00) begin n_fail++; $display("FAIL lu_advance got rd=%0d sel=%b exp 8 00", wb_rd, rs1_hazard); end
        tick();
    endtask

    task automatic test_x0_unused();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);   // writes x0
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);   // reads x0
        tick();
        n_tests++; if (rs1_hazard !== 2'b00 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL x0_sel got %b/%b exp 00/00", rs1_hazard, rs2_hazard); end
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        n_tests++; if (rs1_hazard !== 2'b00 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL unused_rs2 got %b/%b exp 00/00", rs1_hazard, rs2_hazard); end
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd10, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        n_tests++; if (rs1_hazard !== 2'b01 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL indep_sel got %b/%b exp 01/00", rs1_hazard, rs2_hazard); end
        idle_id();
        tick(); tick();
    endtask

    task automatic test_flush();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd11, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++; if (ex_valid !== 1'b0 || rs1_hazard !== 2'b00 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL flush_bubble got ex=%b sel=%b/%b exp 0 00/00", ex_valid, rs1_hazard, rs2_hazard); end
        drive_id(1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        n_tests++; if (ex_valid !== 1'b1 || rs1_hazard !== 2'b00 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL flush_dep got ex=%b sel=%b/%b exp 1 00/00", ex_valid, rs1_hazard, rs2_hazard); end
        idle_id();
        tick(); tick();
    endtask

    task automatic test_ready_high();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b1);  // lw x15
        tick();
        drive_id(1'b1, 5'd2, 5'd15, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        dmem_ready = 1'b1;
        tick();
        idle_id();
        n_tests++; if (stall !== 1'b0 || stall_cnt !== 4'd3) begin n_fail++; $display("FAIL rdy_nostall got stall=%b cnt=%0d exp 0 3", stall, stall_cnt); end
        n_tests++; if (rs1_hazard !== 2'b00 || rs2_hazard !== 2'b10) begin n_fail++; $display("FAIL rdy_sel got %b/%b exp 00/10", rs1_hazard, rs2_hazard); end
        tick(); tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1);  // lw x13
        tick();
        idle_id();
        dmem_ready = 1'b0;
        tick();
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_stall1 got %b exp 1", stall); end
        tick();
        n_tests++; if (stall !== 1'b1 || stall_cnt !== 4'd4) begin n_fail++; $display("FAIL rms_stall2 got stall=%b cnt=%0d exp 1 4", stall, stall_cnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rms_cleared got stall=%b cnt=%0d exp 0 0", stall, stall_cnt); end
        n_tests++; if (ex_valid !== 1'b0 || wb_valid !== 1'b0 || rs1_hazard !== 2'b00 || rs2_hazard !== 2'b00) begin n_fail++; $display("FAIL rms_slots got ex=%b wb=%b sel=%b/%b exp 0 0 00/00", ex_valid, wb_valid, rs1_hazard, rs2_hazard); end
        dmem_ready = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b1);  // lw x14
        tick();
        drive_id(1'b1, 5'd14, 5'd14, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        dmem_ready = 1'b0;
        tick();
        idle_id();
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = (i + 1 >= 15) ? 4'd15 : 4'(i + 1);
            n_tests++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt, exp_cnt); end
            n_tests++; if (rs1_hazard !== 2'b10 || rs2_hazard !== 2'b10) begin n_fail++; $display("FAIL sat_sel[%0d] got %b/%b exp 10/10", i, rs1_hazard, rs2_hazard); end
        end
        dmem_ready = 1'b1;
        tick();
        n_tests++; if (stall_cnt !== 4'd15 || stall !== 1'b0) begin n_fail++; $display("FAIL sat_release got cnt=%0d stall=%b exp 15 0", stall_cnt, stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_ready_high();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
